alu_issue_ctrl: RTL and testbench
=================================

Name: alu_issue_ctrl

Overview:
Command front-end for the ALU unit cluster (arithmetic, logic, compare, shift units). It accepts ALU commands over a valid/ready interface and buffers them in a small FIFO. For each command it decodes the 4-bit opcode into one unit enable plus a 2-bit sub-function, and drives operands for one issue cycle. It captures the selected unit's registered result and presents it on a valid/ready result port. It sits directly upstream of the units and also collects their outputs.

Parameters:
WIDTH, 4, operand width; unit results are WIDTH bits, except arithmetic, which is 2*WIDTH bits
DEPTH, 4, command FIFO entries; power of two, >= 2

Ports:
CLK  in  1  clock; all logic on rising edge
RST  in  1  synchronous, active-high reset
CMD_VALID  in  1  command present
CMD_READY  out  1  FIFO can accept; equals !full
CMD_A  in  WIDTH  operand A
CMD_B  in  WIDTH  operand B
CMD_FUN  in  4  opcode; [3:2] unit select (00 arith, 01 logic, 10 cmp, 11 shift), [1:0] sub-function
CMD_COUNT  out  $clog2(DEPTH+1)  FIFO occupancy
A  out  WIDTH  operand A to units (registered)
B  out  WIDTH  operand B to units (registered)
ALU_FUN  out  2  sub-function to units (registered)
Arith_Enable  out  1  arithmetic unit enable (registered)
Logic_Enable  out  1  logic unit enable (registered)
CMP_Enable  out  1  compare unit enable (registered)
Shift_Enable  out  1  shift unit enable (registered)
Arith_OUT  in  2*WIDTH  arithmetic unit registered result
Logic_OUT  in  WIDTH  logic unit registered result
CMP_OUT  in  WIDTH  compare unit registered result
Shift_OUT  in  WIDTH  shift unit registered result
RES_OUT  out  2*WIDTH  captured result
RES_UNIT  out  2  unit that produced RES_OUT (CMD_FUN[3:2])
RES_VALID  out  1  result available
RES_READY  in  1  consumer accepts result

Behaviour:
- Reset (RST=1 at an edge), including mid-operation or with RES_VALID high:
  - FIFO emptied; CMD_COUNT=0; CMD_READY=1 the following cycle.
  - FSM goes to IDLE; any in-flight command is discarded.
  - A, B, ALU_FUN, all enables, RES_OUT, RES_UNIT and RES_VALID go to 0.
- FIFO:
  - Push on CMD_VALID && CMD_READY, storing {CMD_FUN, CMD_A, CMD_B}. No push when full.
  - Pop only as described for the FSM.
  - Simultaneous push and pop leaves CMD_COUNT unchanged.
  - Pointers wrap modulo DEPTH. CMD_COUNT reflects registered occupancy.
- FSM states: IDLE, ISSUE, WAIT, DONE.
  - IDLE: if FIFO not empty -> pop head, load A/B/ALU_FUN and the decoded enable, go to ISSUE. Otherwise stay.
  - ISSUE (exactly 1 cycle): exactly one enable high, per CMD_FUN[3:2]. The unit registers its result at the closing edge. Go to WAIT.
  - WAIT (1 cycle): all enables low. At the closing edge, capture the selected unit's output into RES_OUT, record RES_UNIT, and set RES_VALID. Go to DONE.
  - DONE: RES_VALID=1. RES_OUT/RES_UNIT are held stable until the handshake.
    - On RES_READY=1 with FIFO not empty: pop and go directly to ISSUE; RES_VALID drops.
    - On RES_READY=1 with FIFO empty: go to IDLE; RES_VALID drops.
    - On RES_READY=0: stay in DONE.
- Enables are low in every state except ISSUE. A/B/ALU_FUN hold their last issued values until the next issue.
- Result width rule: arithmetic result is taken at full 2*WIDTH. Logic/cmp/shift results are zero-extended into RES_OUT[2*WIDTH-1:WIDTH].
- Unit status flags are not used; capture timing is fixed by the FSM.
- Latency: a command accepted in cycle t into an empty FIFO with the FSM idle is popped at the end of t+1, issued in t+2, and produces RES_VALID in t+4.
- Sustained throughput with RES_READY tied high: one result per 3 cycles.
- All 16 opcodes are legal; there is no error path.

Test Plan:
1. WIDTH=4. Push FUN=0101 (logic OR), A=4'hA, B=4'h5; unit model returns 4'hF one cycle after Logic_Enable -> Logic_Enable high exactly one cycle (t+2), ALU_FUN=01; RES_VALID at t+4 with RES_OUT=8'h0F, RES_UNIT=01.
2. Push FUN=0010 (arith), A=4'hF, B=4'hF; model Arith_OUT=8'hE1 -> RES_OUT=8'hE1 (upper bits kept), RES_UNIT=00, only Arith_Enable pulsed.
3. RES_READY=0. Push 5 commands back-to-back -> the first is popped. CMD_READY drops after occupancy reaches 4; the 6th CMD_VALID is not accepted; CMD_COUNT=4. RES_OUT is held stable while RES_READY=0.
4. With 3 queued commands, raise RES_READY permanently -> the remaining results appear in FIFO order, RES_VALID pulses every 3 cycles, and no enable is asserted outside ISSUE.
5. Assert RST during ISSUE with 2 commands queued -> next cycle all outputs are 0, CMD_COUNT=0, CMD_READY=1, and no RES_VALID appears for the discarded commands.
6. Push and pop in the same cycle (DONE handshake while CMD_VALID=1, FIFO non-full) -> CMD_COUNT unchanged, and entries are still issued in order after the pointers wrap past DEPTH.

Source files
------------

// File: rtl/alu_issue_ctrl_if.sv
// Bundle of command, unit-side and result signals for the ALU issue controller.
interface alu_issue_ctrl_if #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic                 CMD_VALID;
    logic                 CMD_READY;
    logic [WIDTH-1:0]     CMD_A;
    logic [WIDTH-1:0]     CMD_B;
    logic [3:0]           CMD_FUN;
    logic [CW-1:0]        CMD_COUNT;
    logic [WIDTH-1:0]     A;
    logic [WIDTH-1:0]     B;
    logic [1:0]           ALU_FUN;
    logic                 Arith_Enable;
    logic                 Logic_Enable;
    logic                 CMP_Enable;
    logic                 Shift_Enable;
    logic [2*WIDTH-1:0]   Arith_OUT;
    logic [WIDTH-1:0]     Logic_OUT;
    logic [WIDTH-1:0]     CMP_OUT;
    logic [WIDTH-1:0]     Shift_OUT;
    logic [2*WIDTH-1:0]   RES_OUT;
    logic [1:0]           RES_UNIT;
    logic                 RES_VALID;
    logic                 RES_READY;

    modport slave (
        input  CMD_VALID, CMD_A, CMD_B, CMD_FUN,
        input  Arith_OUT, Logic_OUT, CMP_OUT, Shift_OUT, RES_READY,
        output CMD_READY, CMD_COUNT, A, B, ALU_FUN,
        output Arith_Enable, Logic_Enable, CMP_Enable, Shift_Enable,
        output RES_OUT, RES_UNIT, RES_VALID
    );

    modport master (
        output CMD_VALID, CMD_A, CMD_B, CMD_FUN,
        output Arith_OUT, Logic_OUT, CMP_OUT, Shift_OUT, RES_READY,
        input  CMD_READY, CMD_COUNT, A, B, ALU_FUN,
        input  Arith_Enable, Logic_Enable, CMP_Enable, Shift_Enable,
        input  RES_OUT, RES_UNIT, RES_VALID
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// ALU command front-end: queues commands, issues one unit per command for a
// single cycle, captures that unit's registered result and presents it on a valid/ready port.
module alu_issue_ctrl #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input logic             CLK,
    input logic             RST,
    alu_issue_ctrl_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int EW = 4 + 2 * WIDTH;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t               state, state_nxt;
    logic [EW-1:0]        mem [DEPTH];
    logic [PW-1:0]        wr_ptr, rd_ptr;
    logic [CW-1:0]        count;
    logic                 full, empty, push, pop, capture, res_take;
    logic [EW-1:0]        head;
    logic [WIDTH-1:0]     a_q, b_q;
    logic [1:0]           fun_q, unit_q, res_unit_q;
    logic [3:0]           en_q;
    logic [2*WIDTH-1:0]   res_q, res_sel;
    logic                 res_valid_q;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign push  = bus.CMD_VALID && !full;
    assign head  = mem[rd_ptr];

    assign bus.CMD_READY    = !full;
    assign bus.CMD_COUNT    = count;
    assign bus.A            = a_q;
    assign bus.B            = b_q;
    assign bus.ALU_FUN      = fun_q;
    assign bus.Arith_Enable = en_q[0];
    assign bus.Logic_Enable = en_q[1];
    assign bus.CMP_Enable   = en_q[2];
    assign bus.Shift_Enable = en_q[3];
    assign bus.RES_OUT      = res_q;
    assign bus.RES_UNIT     = res_unit_q;
    assign bus.RES_VALID    = res_valid_q;

    always_ff @(posedge CLK) begin
        if (push) mem[wr_ptr] <= {bus.CMD_FUN, bus.CMD_A, bus.CMD_B};
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= state_nxt;
    end

    // A pop always lands in ISSUE, so the enable register doubles as the ISSUE marker.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        capture   = 1'b0;
        res_take  = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop       = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: state_nxt = WAIT;
            WAIT: begin
                capture   = 1'b1;
                state_nxt = DONE;
            end
            DONE: begin
                if (bus.RES_READY) begin
                    res_take = 1'b1;
                    if (!empty) begin
                        pop       = 1'b1;
                        state_nxt = ISSUE;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        res_sel = bus.Arith_OUT;
        case (unit_q)
            2'd1:    res_sel = {{WIDTH{1'b0}}, bus.Logic_OUT};
            2'd2:    res_sel = {{WIDTH{1'b0}}, bus.CMP_OUT};
            2'd3:    res_sel = {{WIDTH{1'b0}}, bus.Shift_OUT};
            default: res_sel = bus.Arith_OUT;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            a_q         <= '0;
            b_q         <= '0;
            fun_q       <= '0;
            unit_q      <= '0;
            en_q        <= '0;
            res_q       <= '0;
            res_unit_q  <= '0;
            res_valid_q <= 1'b0;
        end else begin
            en_q <= pop ? (4'b0001 << head[EW-1 -: 2]) : 4'b0000;
            if (pop) begin
                a_q    <= head[2*WIDTH-1 -: WIDTH];
                b_q    <= head[WIDTH-1:0];
                fun_q  <= head[EW-3 -: 2];
                unit_q <= head[EW-1 -: 2];
            end
            if (capture) begin
                res_q       <= res_sel;
                res_unit_q  <= unit_q;
                res_valid_q <= 1'b1;
            end else if (res_take) begin
                res_valid_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with simple registered unit models.
module tb_alu_issue_ctrl;
    typedef struct {
        logic [3:0] fun;
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] res;
        logic [1:0] unit;
    } vec_t;

    logic CLK;
    logic RST;
    int   errors;
    int   checks;
    vec_t vt [9];

    alu_issue_ctrl_if #(.WIDTH(4), .DEPTH(4)) bus ();
    alu_issue_ctrl #(.WIDTH(4), .DEPTH(4)) dut (.CLK(CLK), .RST(RST), .bus(bus));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // unit models: register a result one cycle after their enable
    always @(posedge CLK) begin
        if (RST) begin
            bus.Arith_OUT <= '0;
            bus.Logic_OUT <= '0;
            bus.CMP_OUT   <= '0;
            bus.Shift_OUT <= '0;
        end else begin
            if (bus.Arith_Enable) bus.Arith_OUT <= {4'h0, bus.A} * {4'h0, bus.B};
            if (bus.Logic_Enable)
                case (bus.ALU_FUN)
                    2'd0: bus.Logic_OUT <= bus.A & bus.B;
                    2'd1: bus.Logic_OUT <= bus.A | bus.B;
                    2'd2: bus.Logic_OUT <= bus.A ^ bus.B;
                    default: bus.Logic_OUT <= ~(bus.A & bus.B);
                endcase
            if (bus.CMP_Enable)
                case (bus.ALU_FUN)
                    2'd0: bus.CMP_OUT <= {3'b0, bus.A == bus.B};
                    2'd1: bus.CMP_OUT <= {3'b0, bus.A > bus.B};
                    2'd2: bus.CMP_OUT <= {3'b0, bus.A < bus.B};
                    default: bus.CMP_OUT <= {3'b0, bus.A != bus.B};
                endcase
            if (bus.Shift_Enable)
                case (bus.ALU_FUN)
                    2'd0: bus.Shift_OUT <= bus.A << bus.B[1:0];
                    2'd1: bus.Shift_OUT <= bus.A >> bus.B[1:0];
                    2'd2: bus.Shift_OUT <= bus.A;
                    default: bus.Shift_OUT <= ~bus.A;
                endcase
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] ens();
        return {bus.Shift_Enable, bus.CMP_Enable, bus.Logic_Enable, bus.Arith_Enable};
    endfunction

    function automatic logic [3:0] onehot(input logic [1:0] u);
        return 4'b0001 << u;
    endfunction

    task automatic step();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic drive_cmd(input int i);
        bus.CMD_VALID = 1'b1;
        bus.CMD_FUN   = vt[i].fun;
        bus.CMD_A     = vt[i].a;
        bus.CMD_B     = vt[i].b;
    endtask

    task automatic run_one(input int i);
        string nm;
        nm = $sformatf("v%0d", i);
        drive_cmd(i);
        step();
        bus.CMD_VALID = 1'b0;
        check({nm, "_count_t1"}, 32'(bus.CMD_COUNT), 32'd1);
        check({nm, "_en_t1"}, 32'(ens()), 32'd0);
        step();
        check({nm, "_en_issue"}, 32'(ens()), 32'(onehot(vt[i].unit)));
        check({nm, "_alu_fun"}, 32'(bus.ALU_FUN), 32'(vt[i].fun[1:0]));
        check({nm, "_a"}, 32'(bus.A), 32'(vt[i].a));
        check({nm, "_b"}, 32'(bus.B), 32'(vt[i].b));
        check({nm, "_valid_t2"}, 32'(bus.RES_VALID), 32'd0);
        step();
        check({nm, "_en_wait"}, 32'(ens()), 32'd0);
        check({nm, "_valid_t3"}, 32'(bus.RES_VALID), 32'd0);
        step();
        check({nm, "_valid_t4"}, 32'(bus.RES_VALID), 32'd1);
        check({nm, "_res"}, 32'(bus.RES_OUT), 32'(vt[i].res));
        check({nm, "_unit"}, 32'(bus.RES_UNIT), 32'(vt[i].unit));
        bus.RES_READY = 1'b1;
        step();
        bus.RES_READY = 1'b0;
        check({nm, "_valid_drop"}, 32'(bus.RES_VALID), 32'd0);
    endtask

    initial begin
        int q3 [6];
        int nres, npush, nsame, cyc;
        logic acc, samepp, seen;
        logic [2:0] prev_cnt;
        logic [2:0] exp_cnt3 [7];
        logic       exp_rdy3 [7];

        errors = 0;
        checks = 0;
        vt[0] = '{4'b0101, 4'hA, 4'h5, 8'h0F, 2'd1};
        vt[1] = '{4'b0010, 4'hF, 4'hF, 8'hE1, 2'd0};
        vt[2] = '{4'b0100, 4'hC, 4'hA, 8'h08, 2'd1};
        vt[3] = '{4'b1001, 4'h7, 4'h3, 8'h01, 2'd2};
        vt[4] = '{4'b1100, 4'h3, 4'h2, 8'h0C, 2'd3};
        vt[5] = '{4'b0000, 4'h9, 4'h7, 8'h3F, 2'd0};
        vt[6] = '{4'b1101, 4'h8, 4'h1, 8'h04, 2'd3};
        vt[7] = '{4'b0111, 4'hF, 4'hF, 8'h00, 2'd1};
        vt[8] = '{4'b1010, 4'h5, 4'h6, 8'h01, 2'd2};
        q3 = '{0, 1, 3, 4, 6, 5};
        exp_cnt3 = '{3'd0, 3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
        exp_rdy3 = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

        bus.CMD_VALID = 1'b0;
        bus.CMD_FUN   = '0;
        bus.CMD_A     = '0;
        bus.CMD_B     = '0;
        bus.RES_READY = 1'b0;
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("rst_count", 32'(bus.CMD_COUNT), 32'd0);
        check("rst_ready", 32'(bus.CMD_READY), 32'd1);
        check("rst_valid", 32'(bus.RES_VALID), 32'd0);
        check("rst_en", 32'(ens()), 32'd0);
        check("rst_res", 32'(bus.RES_OUT), 32'd0);
        RST = 1'b0;
        step();

        // single commands, one unit each
        for (int i = 0; i < 9; i++) run_one(i);

        // back-to-back pushes with the consumer stalled
        for (int i = 0; i < 7; i++) begin
            drive_cmd(q3[(i < 6) ? i : 5]);
            check($sformatf("fill_count_c%0d", i), 32'(bus.CMD_COUNT), 32'(exp_cnt3[i]));
            check($sformatf("fill_ready_c%0d", i), 32'(bus.CMD_READY), 32'(exp_rdy3[i]));
            step();
        end
        bus.CMD_VALID = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("stall_count", 32'(bus.CMD_COUNT), 32'd4);
            check("stall_valid", 32'(bus.RES_VALID), 32'd1);
            check("stall_res", 32'(bus.RES_OUT), 32'(vt[q3[0]].res));
            check("stall_unit", 32'(bus.RES_UNIT), 32'(vt[q3[0]].unit));
            step();
        end

        // drain with the consumer always ready: one result every third cycle
        bus.RES_READY = 1'b1;
        for (int j = 0; j < 15; j++) begin
            if (j % 3 == 0 && j <= 12) begin
                check($sformatf("drain_valid_j%0d", j), 32'(bus.RES_VALID), 32'd1);
                check($sformatf("drain_res_j%0d", j), 32'(bus.RES_OUT), 32'(vt[q3[j/3]].res));
                check($sformatf("drain_unit_j%0d", j), 32'(bus.RES_UNIT), 32'(vt[q3[j/3]].unit));
            end else begin
                check($sformatf("drain_novalid_j%0d", j), 32'(bus.RES_VALID), 32'd0);
            end
            if (j % 3 == 1 && j <= 10)
                check($sformatf("drain_en_j%0d", j), 32'(ens()), 32'(onehot(vt[q3[(j-1)/3 + 1]].unit)));
            else
                check($sformatf("drain_noen_j%0d", j), 32'(ens()), 32'd0);
            step();
        end
        bus.RES_READY = 1'b0;

        // reset while ISSUE is active with two commands still queued
        for (int i = 0; i < 4; i++) begin
            drive_cmd(i);
            step();
        end
        bus.CMD_VALID = 1'b0;
        check("r5_done_valid", 32'(bus.RES_VALID), 32'd1);
        bus.RES_READY = 1'b1;
        step();
        check("r5_issue_en", 32'(ens()), 32'(onehot(vt[1].unit)));
        check("r5_issue_count", 32'(bus.CMD_COUNT), 32'd2);
        RST = 1'b1;
        bus.RES_READY = 1'b0;
        step();
        RST = 1'b0;
        check("r5_count", 32'(bus.CMD_COUNT), 32'd0);
        check("r5_ready", 32'(bus.CMD_READY), 32'd1);
        check("r5_en", 32'(ens()), 32'd0);
        check("r5_a", 32'(bus.A), 32'd0);
        check("r5_b", 32'(bus.B), 32'd0);
        check("r5_fun", 32'(bus.ALU_FUN), 32'd0);
        check("r5_res", 32'(bus.RES_OUT), 32'd0);
        check("r5_unit", 32'(bus.RES_UNIT), 32'd0);
        check("r5_valid", 32'(bus.RES_VALID), 32'd0);
        bus.RES_READY = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            seen = seen | bus.RES_VALID | (|ens());
            step();
        end
        check("r5_no_ghost", 32'(seen), 32'd0);
        check("r5_count_after", 32'(bus.CMD_COUNT), 32'd0);

        // streaming with simultaneous push/pop and pointer wrap
        nres = 0; npush = 0; nsame = 0; cyc = 0;
        while (nres < 7 && cyc < 100) begin
            if (npush < 7) drive_cmd(npush);
            else bus.CMD_VALID = 1'b0;
            acc = bus.CMD_VALID && bus.CMD_READY;
            samepp = acc && bus.RES_VALID && (bus.CMD_COUNT != 0);
            prev_cnt = bus.CMD_COUNT;
            if (bus.RES_VALID) begin
                check($sformatf("s6_res_%0d", nres), 32'(bus.RES_OUT), 32'(vt[nres].res));
                check($sformatf("s6_unit_%0d", nres), 32'(bus.RES_UNIT), 32'(vt[nres].unit));
                nres++;
            end
            step();
            cyc++;
            if (acc) npush++;
            if (samepp) begin
                nsame++;
                check("s6_pushpop_count", 32'(bus.CMD_COUNT), 32'(prev_cnt));
            end
        end
        bus.CMD_VALID = 1'b0;
        check("s6_results", 32'(nres), 32'd7);
        check("s6_pushpop_seen", 32'(nsame > 0), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
